// File: rtl/sram_master_if.sv
// sram_if_t: single-port SRAM access bundle.
// Ports:
//   wen   - write enable; a cycle with wen=0 is a read of addr.
//   addr  - word address.
//   wdata - write data.
//   rdata - read data, updated one clock after a cycle with wen=0.
interface sram_if_t #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 32
);
   logic          wen;
   logic [AW-1:0] addr;
   logic [DW-1:0] wdata;
   logic [DW-1:0] rdata;

   modport master (output wen, output addr, output wdata, input rdata);
   modport slave  (input wen, input addr, input wdata, output rdata);
endinterface

// File: rtl/sram_master.sv
// sram_master: turns a valid/ready request/response channel into single-port
// SRAM accesses. Byte-strobed partial writes become read-modify-write because
// the SRAM has no byte enables. One request is outstanding at a time.
// Ports:
//   clk, rst           - clock, asynchronous active-high reset.
//   req_vld/req_rdy    - request handshake; req_rdy is high only in IDLE.
//   req_wr             - 1 = write, 0 = read.
//   req_addr           - word address.
//   req_wdata/wstrb    - write data and byte strobes (ignored for reads).
//   rsp_vld/rsp_rdy    - response handshake.
//   rsp_wr             - response is a write acknowledge.
//   rsp_rdata          - read data, 0 for writes.
//   sram_rw            - SRAM master port.
module sram_master #(
   parameter int unsigned AW = 10,
   parameter int unsigned DW = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_vld,
   output logic             req_rdy,
   input  logic             req_wr,
   input  logic [AW-1:0]    req_addr,
   input  logic [DW-1:0]    req_wdata,
   input  logic [DW/8-1:0]  req_wstrb,
   output logic             rsp_vld,
   input  logic             rsp_rdy,
   output logic             rsp_wr,
   output logic [DW-1:0]    rsp_rdata,
   sram_if_t.master         sram_rw
);

   localparam int unsigned SW = DW / 8;

   typedef enum logic [2:0] {
      IDLE,
      RD,
      RD_DATA,
      WR,
      RMW_RD,
      RMW_WR,
      RSP
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [DW-1:0]   cap_wdata_q, cap_wdata_d;
   logic [SW-1:0]   cap_wstrb_q, cap_wstrb_d;
   logic            rsp_wr_q, rsp_wr_d;
   logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
   logic            req_rdy_q;
   logic            rsp_vld_q;
   logic [DW-1:0]   merged_c;

   // Byte merge of the captured write data over the word just read back.
   always_comb begin
      merged_c = sram_rw.rdata;
      for (int i = 0; i < int'(SW); i++) begin
         if (cap_wstrb_q[i]) begin
            merged_c[8*i +: 8] = cap_wdata_q[8*i +: 8];
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         addr_q      <= '0;
         wdata_q     <= '0;
         cap_wdata_q <= '0;
         cap_wstrb_q <= '0;
         rsp_wr_q    <= 1'b0;
         rsp_rdata_q <= '0;
         req_rdy_q   <= 1'b1;
         rsp_vld_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         cap_wdata_q <= cap_wdata_d;
         cap_wstrb_q <= cap_wstrb_d;
         rsp_wr_q    <= rsp_wr_d;
         rsp_rdata_q <= rsp_rdata_d;
         req_rdy_q   <= (state_d == IDLE);
         rsp_vld_q   <= (state_d == RSP);
      end
   end

   // Next-state and datapath update.
   always_comb begin
      state_d     = state_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      cap_wdata_d = cap_wdata_q;
      cap_wstrb_d = cap_wstrb_q;
      rsp_wr_d    = rsp_wr_q;
      rsp_rdata_d = rsp_rdata_q;

      case (state_q)
         IDLE: begin
            if (req_vld) begin
               if (!req_wr) begin
                  state_d = RD;
                  addr_d  = req_addr;
               end else if (&req_wstrb) begin
                  state_d = WR;
                  addr_d  = req_addr;
                  wdata_d = req_wdata;
               end else if (|req_wstrb) begin
                  state_d     = RMW_RD;
                  addr_d      = req_addr;
                  cap_wdata_d = req_wdata;
                  cap_wstrb_d = req_wstrb;
               end else begin
                  // Nothing to write: acknowledge without touching the SRAM.
                  state_d     = RSP;
                  rsp_wr_d    = 1'b1;
                  rsp_rdata_d = '0;
               end
            end
         end
         RD: begin
            state_d = RD_DATA;
         end
         RD_DATA: begin
            state_d     = RSP;
            rsp_wr_d    = 1'b0;
            rsp_rdata_d = sram_rw.rdata;
         end
         WR: begin
            state_d     = RSP;
            rsp_wr_d    = 1'b1;
            rsp_rdata_d = '0;
         end
         RMW_RD: begin
            state_d = RMW_WR;
         end
         RMW_WR: begin
            // Keep the merged word so wdata holds its last value afterwards.
            state_d     = RSP;
            wdata_d     = merged_c;
            rsp_wr_d    = 1'b1;
            rsp_rdata_d = '0;
         end
         RSP: begin
            if (rsp_rdy) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // wen is a state decode so an asynchronous reset kills a write at once.
   assign sram_rw.wen   = (state_q == WR) || (state_q == RMW_WR);
   assign sram_rw.addr  = addr_q;
   assign sram_rw.wdata = (state_q == RMW_WR) ? merged_c : wdata_q;

   assign req_rdy   = req_rdy_q;
   assign rsp_vld   = rsp_vld_q;
   assign rsp_wr    = rsp_wr_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_sram_master.sv
module tb_sram_master;
   localparam int unsigned AW = 10;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = DW / 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            req_vld;
   logic            req_rdy;
   logic            req_wr;
   logic [AW-1:0]   req_addr;
   logic [DW-1:0]   req_wdata;
   logic [SW-1:0]   req_wstrb;
   logic            rsp_vld;
   logic            rsp_rdy;
   logic            rsp_wr;
   logic [DW-1:0]   rsp_rdata;

   always #5 clk = ~clk;

   sram_if_t #(.AW(AW), .DW(DW)) sram_bus ();

   sram_master #(.AW(AW), .DW(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .req_vld   (req_vld),
      .req_rdy   (req_rdy),
      .req_wr    (req_wr),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .req_wstrb (req_wstrb),
      .rsp_vld   (rsp_vld),
      .rsp_rdy   (rsp_rdy),
      .rsp_wr    (rsp_wr),
      .rsp_rdata (rsp_rdata),
      .sram_rw   (sram_bus)
   );

   // SRAM model: write when wen, otherwise rdata follows addr one clock later.
   logic [DW-1:0] mem [1 << AW] = '{default: '0};
   always @(posedge clk) begin
      if (sram_bus.wen) mem[sram_bus.addr] <= sram_bus.wdata;
      else              sram_bus.rdata     <= mem[sram_bus.addr];
   end

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [DW-1:0] exp_word;   // read data, or word written to the SRAM
   } vec_t;

   typedef struct {
      logic          wr;
      logic [AW-1:0] addr;
      logic [DW-1:0] exp_rdata;
      logic [DW-1:0] exp_wdata;
      int            lat;
      int            exp_wen;
      int            wen_off;
      int            acc_cyc;
      int            wen_base;
   } sb_t;

   sb_t sbq[$];

   int n_vec = 0;
   int n_bad = 0;
   int cyc = 0;
   int wen_cnt = 0;
   int last_wen_cyc = 0;
   logic [DW-1:0] last_wdata = '0;
   logic [AW-1:0] last_waddr = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Response monitor / scoreboard consumer.
   logic          vld_seen = 1'b0;
   logic [DW-1:0] vld_rdata = '0;
   logic          vld_wr = 1'b0;
   always @(negedge clk) begin
      if (!rst) begin
         if (sram_bus.wen) begin
            wen_cnt++;
            last_wen_cyc = cyc;
            last_wdata   = sram_bus.wdata;
            last_waddr   = sram_bus.addr;
         end
         if (rsp_vld) begin
            if (sbq.size() == 0) begin
               n_vec++;
               n_bad++;
               $display("FAIL rsp_unexpected: got rsp_vld=1 expected no response (cycle %0d)", cyc);
            end else begin
               if (!vld_seen) begin
                  vld_seen  = 1'b1;
                  vld_rdata = rsp_rdata;
                  vld_wr    = rsp_wr;
                  chk("rsp_latency", 32'(cyc - sbq[0].acc_cyc), 32'(sbq[0].lat));
               end else begin
                  chk("rsp_rdata_stable", rsp_rdata, vld_rdata);
                  chk("rsp_wr_stable", 32'(rsp_wr), 32'(vld_wr));
               end
               if (rsp_rdy) begin
                  sb_t e;
                  e = sbq.pop_front();
                  vld_seen = 1'b0;
                  chk("rsp_rdata", rsp_rdata, e.exp_rdata);
                  chk("rsp_wr", 32'(rsp_wr), 32'(e.wr));
                  chk("wen_pulses", 32'(wen_cnt - e.wen_base), 32'(e.exp_wen));
                  if (e.exp_wen != 0) begin
                     chk("wen_cycle", 32'(last_wen_cyc - e.acc_cyc), 32'(e.wen_off));
                     chk("sram_wdata", last_wdata, e.exp_wdata);
                     chk("sram_addr", 32'(last_waddr), 32'(e.addr));
                  end
               end
            end
         end
      end
   end

   // Issue one request (entered and left at posedge+1) and push its expectation.
   task automatic send(input logic wr, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                       input logic [SW-1:0] wstrb, input logic [DW-1:0] exp_word, output int acc);
      sb_t e;
      int  n;
      bit  done;
      req_vld   = 1'b1;
      req_wr    = wr;
      req_addr  = addr;
      req_wdata = wdata;
      req_wstrb = wstrb;
      n    = 0;
      done = 1'b0;
      acc  = -1;
      while (!done) begin
         @(negedge clk);
         if (req_rdy) begin
            done = 1'b1;
         end else begin
            n++;
            if (n > 50) begin
               n_vec++;
               n_bad++;
               $display("FAIL req_accept_timeout: got no req_rdy in 50 cycles expected acceptance (addr 0x%03h)", addr);
               done = 1'b1;
            end
         end
      end
      if (req_rdy) begin
         e.wr        = wr;
         e.addr      = addr;
         e.exp_rdata = wr ? '0 : exp_word;
         e.exp_wdata = exp_word;
         e.lat       = !wr ? 3 : ((&wstrb) ? 2 : ((wstrb == '0) ? 1 : 3));
         e.exp_wen   = (wr && (wstrb != '0)) ? 1 : 0;
         e.wen_off   = (&wstrb) ? 1 : 2;
         e.acc_cyc   = cyc;
         e.wen_base  = wen_cnt;
         sbq.push_back(e);
         acc = cyc;
      end
      @(posedge clk);
      #1;
      req_vld   = 1'b0;
      req_wdata = $urandom;
      req_wstrb = SW'($urandom);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((sbq.size() != 0 || !req_rdy) && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (n >= 100) begin
         n_vec++;
         n_bad++;
         $display("FAIL drain_timeout: got %0d responses pending expected 0", sbq.size());
      end
   endtask

   vec_t tbl[14];
   int   a0, a1, a2, wbase, n;

   initial begin
      tbl[0]  = '{1'b1, 10'h005, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF};
      tbl[1]  = '{1'b0, 10'h005, 32'h5A5A5A5A, 4'hF, 32'hDEADBEEF};
      tbl[2]  = '{1'b1, 10'h005, 32'h00001234, 4'h3, 32'hDEAD1234};
      tbl[3]  = '{1'b0, 10'h005, 32'h00000000, 4'h0, 32'hDEAD1234};
      tbl[4]  = '{1'b1, 10'h005, 32'hFFFFFFFF, 4'h0, 32'h00000000};
      tbl[5]  = '{1'b0, 10'h005, 32'hFFFFFFFF, 4'hF, 32'hDEAD1234};
      tbl[6]  = '{1'b1, 10'h3FF, 32'h11223344, 4'hF, 32'h11223344};
      tbl[7]  = '{1'b0, 10'h3FF, 32'h00000000, 4'hF, 32'h11223344};
      tbl[8]  = '{1'b1, 10'h3FF, 32'hEE000000, 4'h8, 32'hEE223344};
      tbl[9]  = '{1'b0, 10'h3FF, 32'h00000000, 4'h0, 32'hEE223344};
      tbl[10] = '{1'b1, 10'h010, 32'hAABBCCDD, 4'h5, 32'h00BB00DD};
      tbl[11] = '{1'b0, 10'h010, 32'h00000000, 4'h0, 32'h00BB00DD};
      tbl[12] = '{1'b1, 10'h010, 32'h12345678, 4'h6, 32'h003456DD};
      tbl[13] = '{1'b0, 10'h010, 32'h00000000, 4'h0, 32'h003456DD};

      rst       = 1'b1;
      req_vld   = 1'b0;
      req_wr    = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_wstrb = '0;
      rsp_rdy   = 1'b1;

      // Reset values.
      #12;
      chk("rst_req_rdy", 32'(req_rdy), 32'd1);
      chk("rst_rsp_vld", 32'(rsp_vld), 32'd0);
      chk("rst_rsp_wr", 32'(rsp_wr), 32'd0);
      chk("rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rst_wen", 32'(sram_bus.wen), 32'd0);
      chk("rst_addr", 32'(sram_bus.addr), 32'd0);
      chk("rst_wdata", sram_bus.wdata, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;

      // Table-driven sequence, back to back with rsp_rdy held high.
      for (int i = 0; i < 14; i++) begin
         send(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].wstrb, tbl[i].exp_word, a0);
      end
      drain();

      // Back-pressure on a read response.
      rsp_rdy = 1'b0;
      send(1'b0, 10'h005, 32'h0, 4'h0, 32'hDEAD1234, a0);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!rsp_vld && n < 20);
      chk("bp_rsp_vld_seen", 32'(rsp_vld), 32'd1);
      wbase = wen_cnt;
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_vld", 32'(rsp_vld), 32'd1);
         chk("bp_req_rdy", 32'(req_rdy), 32'd0);
         chk("bp_wen", 32'(sram_bus.wen), 32'd0);
      end
      chk("bp_no_write", 32'(wen_cnt - wbase), 32'd0);
      @(posedge clk);
      #1;
      rsp_rdy = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_rsp_vld_drop", 32'(rsp_vld), 32'd0);
      chk("bp_req_rdy_back", 32'(req_rdy), 32'd1);
      @(posedge clk);
      #1;

      // Reset while the read half of a read-modify-write is in flight.
      wbase     = wen_cnt;
      req_vld   = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 10'h3FF;
      req_wdata = 32'h5555AAAA;
      req_wstrb = 4'h3;
      @(negedge clk);
      chk("rmw_rst_accept", 32'(req_rdy), 32'd1);
      @(posedge clk);
      #1;
      req_vld = 1'b0;
      chk("rmw_rst_in_rmw_rd", 32'(req_rdy), 32'd0);
      #1;
      rst = 1'b1;
      #1;
      chk("rmw_rst_req_rdy", 32'(req_rdy), 32'd1);
      chk("rmw_rst_rsp_vld", 32'(rsp_vld), 32'd0);
      chk("rmw_rst_rsp_wr", 32'(rsp_wr), 32'd0);
      chk("rmw_rst_rsp_rdata", rsp_rdata, 32'd0);
      chk("rmw_rst_wen", 32'(sram_bus.wen), 32'd0);
      chk("rmw_rst_addr", 32'(sram_bus.addr), 32'd0);
      chk("rmw_rst_wdata", sram_bus.wdata, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("rmw_rst_no_write", 32'(wen_cnt - wbase), 32'd0);
      @(posedge clk);
      #1;
      send(1'b0, 10'h3FF, 32'h0, 4'h0, 32'hEE223344, a0);
      drain();

      // Back-to-back spacing: read, full write, read.
      send(1'b0, 10'h000, 32'h0, 4'h0, 32'h00000000, a0);
      send(1'b1, 10'h3FF, 32'h0A0B0C0D, 4'hF, 32'h0A0B0C0D, a1);
      send(1'b0, 10'h3FF, 32'h0, 4'h0, 32'h0A0B0C0D, a2);
      chk("b2b_read_spacing", 32'(a1 - a0), 32'd4);
      chk("b2b_write_spacing", 32'(a2 - a1), 32'd3);
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sram_master.md
Name: sram_master

Overview:
- Initiator end of the sram_if_t single-port SRAM interface.
- Converts a valid/ready request/response channel into sram_if_t master accesses.
- The SRAM model has no byte enables, so partial writes (byte strobes) are done as read-modify-write.
- Sits between a core/bus-side port and one SRAM instance; handles one outstanding request at a time.

Parameters:
- AW, 10, word address width; must match the attached SRAM.
- DW, 32, data width; must be a multiple of 8. Strobe width is DW/8.

Ports:
- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- req_vld  input  1  request valid.
- req_rdy  output  1  request ready.
- req_wr  input  1  1 = write, 0 = read.
- req_addr  input  AW  word address.
- req_wdata  input  DW  write data.
- req_wstrb  input  DW/8  byte strobes, writes only; bit i covers wdata[8i+7:8i].
- rsp_vld  output  1  response valid.
- rsp_rdy  input  1  response ready.
- rsp_wr  output  1  response is a write acknowledge.
- rsp_rdata  output  DW  read data; 0 for writes.
- sram_rw  sram_if_t.master  -  drives wen, addr and wdata; samples rdata. The SRAM updates rdata one clock after any cycle with wen=0.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: state IDLE; req_rdy=1; rsp_vld=0; rsp_wr=0; rsp_rdata=0; sram_rw.wen=0; sram_rw.addr=0; sram_rw.wdata=0.
- sram_rw.wen is decoded from state, so reset suppresses an in-flight write in the same cycle.
- Request capture: a handshake (req_vld & req_rdy) at cycle T registers addr, wr, wdata and wstrb.
- req_rdy=1 only in IDLE.
- States and transitions:
  - IDLE: on handshake, go to RD (read), WR (write with wstrb all ones), RMW_RD (write with partial nonzero wstrb) or RSP (write with wstrb=0).
  - RD (T+1): wen=0, addr=captured address → RD_DATA.
  - RD_DATA (T+2): capture sram_rw.rdata into rsp_rdata; set rsp_wr=0 → RSP. rsp_vld=1 from T+3.
  - WR (T+1): wen=1, addr, wdata=captured data; set rsp_wr=1, rsp_rdata=0 → RSP. rsp_vld=1 from T+2.
  - RMW_RD (T+1): wen=0, addr → RMW_WR.
  - RMW_WR (T+2): wen=1. wdata per byte i = wstrb[i] ? req byte : sram_rw.rdata byte. Set rsp_wr=1 → RSP. rsp_vld=1 from T+3.
  - wstrb=0 write: no SRAM access (wen never asserted); rsp_wr=1, rsp_vld=1 from T+1.
  - RSP: rsp_vld=1. rsp_wr and rsp_rdata are stable while rsp_rdy=0. On rsp_vld & rsp_rdy → IDLE and rsp_vld=0 next cycle.
- Back-pressure: no new request is accepted while a response is pending. Next acceptance is no earlier than the cycle after the response handshake.
- SRAM outside an access: wen=0, addr holds its last value, wdata holds its last value.
- wen is high for exactly one cycle per write with nonzero strobes; never high for reads.
- Addresses are AW bits wide, so 2**AW-1 is valid and there is no wrap or overflow logic.
- req_wstrb and req_wdata are ignored for reads.
- Minimum request spacing with rsp_rdy=1: read 4 cycles, full write 3 cycles, partial write 4 cycles, zero-strobe write 2 cycles.
- Reset mid-operation: return to IDLE immediately. The pending response is discarded. An RMW interrupted before RMW_WR leaves memory unchanged.

Test Plan:
- Full write then read: write addr 0x005, wdata 0xDEADBEEF, wstrb 0xF, accepted at T → wen=1 at T+1 only, rsp_vld/rsp_wr=1 at T+2. Read addr 0x005 → rsp_rdata=0xDEADBEEF, rsp_wr=0, rsp_vld at accept+3.
- Partial write on top of that: addr 0x005, wdata 0x00001234, wstrb 0x3 → wen=0 at T+1, wen=1 with wdata 0xDEAD1234 at T+2, rsp at T+3. Read-back gives 0xDEAD1234.
- Back-pressure: read with rsp_rdy=0 for 5 cycles after rsp_vld → rsp_vld=1, rsp_rdata stable, req_rdy=0, wen=0 throughout. rsp_rdy=1 → rsp_vld=0 and req_rdy=1 next cycle.
- Zero strobe: write addr 0x005, wdata 0xFFFFFFFF, wstrb 0x0 → wen never asserted, rsp at T+1. Read-back still 0xDEAD1234.
- Reset mid-RMW: partial write to 0x3FF, rst pulsed in RMW_RD → all outputs at reset values asynchronously, no write. Read 0x3FF returns the prior value.
- Back-to-back with rsp_rdy held 1: read 0x000, full write 0x3FF with 0x0A0B0C0D, read 0x3FF → responses in order, last rsp_rdata=0x0A0B0C0D. Acceptances spaced 4 cycles after the read and 3 cycles after the write.
